// File: rtl/fifo_uart_tx_if.sv
// Signal bundle between the byte FIFO, the UART transmitter and whoever watches the line.
// master = transmitter side (pops the FIFO, drives the line); slave = FIFO/host side.
interface fifo_uart_tx_if;
  logic       tx_en;
  logic       buf_empty;
  logic [7:0] buf_out;
  logic       rd_en;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;
  logic [7:0] tx_count;

  modport master (
    input  tx_en, buf_empty, buf_out,
    output rd_en, tx, tx_busy, tx_done, tx_count
  );

  modport slave (
    output tx_en, buf_empty, buf_out,
    input  rd_en, tx, tx_busy, tx_done, tx_count
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a FIFO and sends them as 8N1/8N2 UART frames, LSB first.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic           clk,
  input  logic           rst,
  fifo_uart_tx_if.master bus
);
  // Wide enough for two stop bits at the largest legal CLKS_PER_BIT.
  localparam int               CNT_W     = 17;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
`ifdef FIFO_UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] baud_reg, baud_next;
  logic [2:0]       bit_idx_reg, bit_idx_next;
  logic [7:0]       shift_reg, shift_next;
  logic             tx_reg, tx_next;
  logic [7:0]       count_reg, count_next;
  logic             rd_en_c;
  logic             done_c;
  logic             bit_end;
  logic             stop_end;
`ifdef FIFO_UART_TX_PARITY_EN
  logic             parity_reg, parity_next;
`endif

  always_comb begin
    state_next   = state_reg;
    baud_next    = baud_reg;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    count_next   = count_reg;
    rd_en_c      = 1'b0;
    done_c       = 1'b0;
    bit_end      = (baud_reg == BIT_LAST);
    stop_end     = (baud_reg == STOP_LAST);
`ifdef FIFO_UART_TX_PARITY_EN
    parity_next  = parity_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (bus.tx_en && !bus.buf_empty) state_next = FETCH;
      end
      FETCH: begin
        rd_en_c    = 1'b1;
        state_next = LOAD;
      end
      LOAD: begin
        // FIFO read data is valid in the cycle after the pop.
        shift_next   = bus.buf_out;
        baud_next    = '0;
        bit_idx_next = '0;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_next  = ^bus.buf_out;
`endif
        state_next   = START;
      end
      START: begin
        if (bit_end) begin
          baud_next  = '0;
          state_next = DATA;
        end else begin
          baud_next = baud_reg + CNT_ONE;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_next    = '0;
          shift_next   = {1'b0, shift_reg[7:1]};
          bit_idx_next = bit_idx_reg + 3'd1;
          if (bit_idx_reg == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end else begin
          baud_next = baud_reg + CNT_ONE;
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          baud_next  = '0;
          state_next = STOP;
        end else begin
          baud_next = baud_reg + CNT_ONE;
        end
      end
`endif
      STOP: begin
        if (stop_end) begin
          baud_next  = '0;
          done_c     = 1'b1;
          count_next = count_reg + 8'd1;
          state_next = (bus.tx_en && !bus.buf_empty) ? FETCH : IDLE;
        end else begin
          baud_next = baud_reg + CNT_ONE;
        end
      end
      default: state_next = IDLE;
    endcase

    // Line level is registered from the next state so tx lines up with state_reg.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY:  tx_next = parity_next;
`endif
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      baud_reg    <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      tx_reg      <= 1'b1;
      count_reg   <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_reg  <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      baud_reg    <= baud_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
      tx_reg      <= tx_next;
      count_reg   <= count_next;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_reg  <= parity_next;
`endif
    end
  end

  assign bus.rd_en    = rd_en_c;
  assign bus.tx       = tx_reg;
  assign bus.tx_busy  = (state_reg != IDLE);
  assign bus.tx_done  = done_c;
  assign bus.tx_count = count_reg;
endmodule
